fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state SHALL update on rising edge only.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-003 stall  input  1  decode side cannot accept a new instruction this cycle.
REQ-004 redirect  input  1  branch/jump taken; single-cycle pulse from the later stage.
REQ-005 redirect_pc  input  32  target address, valid when redirect=1.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  32  read address = {pc[31:2],2'b00}.
REQ-008 imem_gnt  input  1  memory accepted the request this cycle.
REQ-009 imem_rvalid  input  1  read data valid, earliest one cycle after gnt.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 fd_wren  output  1  write enable to the fetch/decode stage register.
REQ-012 fd_ins  output  32  instruction to the fetch/decode register.
REQ-013 fd_next_pc  output  32  fetched address + 4 to the fetch/decode register.
REQ-014 pc  output  32  current fetch PC, registered.

Function
REQ-015 SHALL be a 3-state FSM: REQ, WAIT, HOLD, plus 1-bit squash flag, 32-bit hold buffer and 32-bit pc register.
REQ-016 REQ: imem_req=1, imem_addr from pc; on gnt go WAIT; without gnt stay in REQ, holding addr stable.
REQ-017 WAIT: imem_req=0; on rvalid with squash=0 and stall=0, fd_wren=1, fd_ins=rdata, fd_next_pc=pc+4, pc<=pc+4, go REQ.
REQ-018 WAIT, rvalid with squash=0 and stall=1: hold buffer<=rdata, fd_wren=0, go HOLD; pc unchanged.
REQ-019 WAIT, rvalid with squash=1: data dropped, squash<=0, fd_wren=0, go REQ.
REQ-020 HOLD: imem_req=0; when stall=0, fd_wren=1, fd_ins=buffer, fd_next_pc=pc+4, pc<=pc+4, go REQ; while stall=1, stay, fd_wren=0.
REQ-021 redirect (any state) SHALL take priority over stall and rvalid: pc<={redirect_pc[31:2],2'b00}, fd_wren=1, fd_ins=0 (NOP bubble), fd_next_pc=0.
REQ-022 redirect in REQ without gnt: go REQ, next request uses new pc; redirect in REQ with gnt: go WAIT, squash<=1.
REQ-023 redirect in WAIT: squash<=1 unless rvalid is high the same cycle (that data dropped, squash<=0, go REQ); otherwise stay WAIT.
REQ-024 redirect in HOLD: buffer discarded, go REQ.
REQ-025 fd_ins/fd_next_pc SHALL be 0 whenever fd_wren=0.
REQ-026 pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-027 at most one memory request outstanding; rvalid outside WAIT SHALL be ignored.
REQ-028 minimum fetch latency: REQ with gnt at cycle N -> fd_wren at N+1; peak throughput one instruction per 2 cycles.

Reset
REQ-029 reset=1 at an edge: state<=REQ, pc<=0, squash<=0, buffer<=0, overriding all other inputs in any state.
REQ-030 during reset and while reset=1: fd_wren=0, fd_ins=0, fd_next_pc=0; imem_req=0.
REQ-031 first cycle after reset deasserts: imem_req=1, imem_addr=0x00000000.
REQ-032 response arriving after a mid-WAIT reset SHALL be ignored (state is REQ).

Verification
REQ-033 reset, gnt in first cycle, rvalid next with rdata=0x12345678 -> fd_wren=1, fd_ins=0x12345678, fd_next_pc=0x4; next imem_addr=0x4.
REQ-034 gnt withheld 3 cycles at pc=0x4 -> imem_req=1, imem_addr=0x4 stable all 3 cycles; fd_wren=0 throughout.
REQ-035 rvalid rdata=0xAABBCCDD with stall=1 for 2 cycles -> fd_wren=0 both; cycle stall falls fd_wren=1, fd_ins=0xAABBCCDD, then request pc+4.
REQ-036 redirect_pc=0x100 in WAIT -> fd_wren=1, fd_ins=0; following rvalid dropped (fd_wren=0); next request imem_addr=0x100.
REQ-037 redirect_pc=0xFFFFFFFE, fetch 0x00000013 -> imem_addr=0xFFFFFFFC, fd_next_pc=0x0, next imem_addr=0x0.
REQ-038 reset=1 in WAIT then released; stale rvalid -> fd_wren=0, first request imem_addr=0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, a single-entry hold
// buffer for decode stalls, and redirect handling with response squashing.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fd_wren,
  output logic [31:0] fd_ins,
  output logic [31:0] fd_next_pc,
  output logic [31:0] pc
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INSN_INC = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              squash_q, squash_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   redirect_tgt;
  logic              unused_rpc_low;

  assign pc_inc         = XLEN'(pc_q + XLEN'(INSN_INC));
  assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_rpc_low = ^redirect_pc[1:0];
  assign imem_addr      = {pc_q[XLEN-1:2], 2'b00};
  assign pc             = pc_q;

  // State, squash flag, hold buffer and pc registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      squash_q <= 1'b0;
      buf_q    <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      buf_q    <= buf_d;
      pc_q     <= pc_d;
    end
  end

  // Next-state and output decode; redirect outranks stall and rvalid.
  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    buf_d      = buf_q;
    pc_d       = pc_q;
    imem_req   = 1'b0;
    fd_wren    = 1'b0;
    fd_ins     = '0;
    fd_next_pc = '0;

    unique case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d    = redirect_tgt;
          fd_wren = 1'b1;
          if (imem_gnt) begin
            state_d  = S_WAIT;
            squash_d = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          fd_wren = 1'b1;
          if (imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else if (stall) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else begin
            fd_wren    = 1'b1;
            fd_ins     = imem_rdata;
            fd_next_pc = pc_inc;
            pc_d       = pc_inc;
            state_d    = S_REQ;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          fd_wren = 1'b1;
          buf_d   = '0;
          state_d = S_REQ;
        end else if (!stall) begin
          fd_wren    = 1'b1;
          fd_ins     = buf_q;
          fd_next_pc = pc_inc;
          pc_d       = pc_inc;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // Reset masks every output combinationally.
    if (reset) begin
      imem_req   = 1'b0;
      fd_wren    = 1'b0;
      fd_ins     = '0;
      fd_next_pc = '0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, compared each cycle against a transaction-level fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fd_wren;
  logic [31:0] fd_ins;
  logic [31:0] fd_next_pc;
  logic [31:0] pc;

  int vectors = 0;
  int errs    = 0;

  // Model: fetch pc, an outstanding read, whether its data must be thrown
  // away, and instructions fetched but not yet accepted by decode.
  logic [31:0] m_pc      = '0;
  bit          m_pending = 1'b0;
  bit          m_drop    = 1'b0;
  bit          m_known   = 1'b0;
  logic [31:0] held_q[$];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fd_wren     (fd_wren),
    .fd_ins      (fd_ins),
    .fd_next_pc  (fd_next_pc),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic rst, input logic stl, input logic rdr,
                       input logic [31:0] rpc, input logic gnt, input logic rv,
                       input logic [31:0] rdat);
    logic        e_req, e_wren;
    logic [31:0] e_ins, e_nxt, tgt;
    bit          issuing;
    @(negedge clk);
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdat;
    #1;
    tgt     = {rpc[31:2], 2'b00};
    issuing = !m_pending && held_q.size() == 0;
    e_req   = !rst && issuing;
    e_wren  = 1'b0;
    e_ins   = '0;
    e_nxt   = '0;
    if (!rst) begin
      if (rdr) begin
        e_wren = 1'b1;
      end else if (held_q.size() != 0) begin
        if (!stl) begin
          e_wren = 1'b1; e_ins = held_q[0]; e_nxt = m_pc + 32'd4;
        end
      end else if (m_pending && rv && !m_drop && !stl) begin
        e_wren = 1'b1; e_ins = rdat; e_nxt = m_pc + 32'd4;
      end
    end

    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("fd_wren", 32'(fd_wren), 32'(e_wren));
    chk("fd_ins", fd_ins, e_ins);
    chk("fd_next_pc", fd_next_pc, e_nxt);
    if (m_known) chk("pc", pc, m_pc);

    if (rst) begin
      m_pc = '0; m_pending = 1'b0; m_drop = 1'b0; m_known = 1'b1;
      held_q.delete();
    end else if (rdr) begin
      m_pc = tgt;
      if (held_q.size() != 0) begin
        held_q.delete();
      end else if (m_pending) begin
        if (rv) begin m_pending = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end else if (gnt) begin
        m_pending = 1'b1; m_drop = 1'b1;
      end
    end else if (held_q.size() != 0) begin
      if (!stl) begin void'(held_q.pop_front()); m_pc = m_pc + 32'd4; end
    end else if (m_pending) begin
      if (rv) begin
        m_pending = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else if (stl) held_q.push_back(rdat);
        else m_pc = m_pc + 32'd4;
      end
    end else if (gnt) begin
      m_pending = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset, then first fetch with immediate grant.
    cycle(1, 0, 0, 32'h0, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0, 1, 1, 32'hDEADBEEF);
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'h12345678);
    // Grant withheld three cycles at pc 0x4.
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'h55555555);
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    // Response under stall parks in the hold buffer for two cycles.
    cycle(0, 1, 0, 32'h0, 0, 1, 32'hAABBCCDD);
    cycle(0, 1, 0, 32'h0, 0, 1, 32'h11111111);
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    // Redirect while waiting squashes the in-flight response.
    cycle(0, 0, 1, 32'h100, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'hBADBAD00);
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'h00000093);
    // Misaligned redirect near the top of memory; pc+4 wraps to zero.
    cycle(0, 0, 1, 32'hFFFFFFFE, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'h00000013);
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    // Reset mid-wait; the stale response must be ignored.
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'hCAFEF00D);
    // Redirect with grant in the same cycle, and redirect while holding.
    cycle(0, 0, 1, 32'h200, 1, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'h77777777);
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 1, 0, 32'h0, 0, 1, 32'h88888888);
    cycle(0, 1, 1, 32'h300, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 1, 32'h404, 0, 1, 32'h99999999);
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) == 0),
            (($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1),
            $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
